// File: rtl/sv_seg_scanner.sv
// sv_seg_scanner: time-multiplexed seven-segment display driver.
//
// Scans NUM_DIGITS digits one at a time onto a shared segment bus. The input word is
// double-buffered: a load lands in a staging register and is copied into the display
// register only when the scan wraps back to digit 0, so a frame never shows a mix of
// old and new digits. All pin outputs are registered.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   enable     0 blanks all anodes/segments; the scan keeps running
//   load       one-cycle strobe capturing value/dp_in
//   value      packed hex word, nibble k = digit k, digit 0 rightmost
//   dp_in      per-digit decimal point enables
//   blank_lz   live leading-zero suppression enable
//   seg        active-low segments {g,f,e,d,c,b,a}
//   dp         active-low decimal point
//   an         active-low one-hot anode select
//   frame_done one-cycle pulse on the first output cycle of digit 0 after a wrap

module sv_seg_scanner #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

    logic [CntW-1:0]         presc_q;
    logic [IdxW-1:0]         idx_q;
    logic [4*NUM_DIGITS-1:0] stage_val_q;
    logic [NUM_DIGITS-1:0]   stage_dp_q;
    logic                    pending_q;
    logic [4*NUM_DIGITS-1:0] disp_val_q;
    logic [NUM_DIGITS-1:0]   disp_dp_q;
    logic                    wrap_q;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] an_d;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        tick       = (presc_q == CntMax);
        wrap       = tick && (idx_q == IdxMax);
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        zero_above = 1'b1;
        an_d       = '1;
        // Walk from the most significant digit down so zero_above holds "this nibble and
        // every nibble above it are zero" when digit k is reached.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (disp_val_q[4*k +: 4] == 4'h0);
            if (idx_q == IdxW'(k)) begin
                cur_nib   = disp_val_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                an_d[k]   = 1'b0;
                cur_blank = blank_lz && zero_above && (k != 0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            stage_val_q <= '0;
            stage_dp_q  <= '0;
            pending_q   <= 1'b0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            wrap_q      <= 1'b0;
            frame_done  <= 1'b0;
            an          <= '1;
            seg         <= 7'h7f;
            dp          <= 1'b1;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                idx_q <= (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
            end

            // Commit only at the wrap; a load on the wrap edge bypasses staging.
            if (load) begin
                stage_val_q <= value;
                stage_dp_q  <= dp_in;
            end
            if (wrap) begin
                pending_q <= 1'b0;
                if (load) begin
                    disp_val_q <= value;
                    disp_dp_q  <= dp_in;
                end else if (pending_q) begin
                    disp_val_q <= stage_val_q;
                    disp_dp_q  <= stage_dp_q;
                end
            end else if (load) begin
                pending_q <= 1'b1;
            end

            // frame_done lines up with the first pin cycle of the freshly committed frame.
            wrap_q     <= wrap;
            frame_done <= wrap_q;

            if (enable) begin
                an  <= an_d;
                seg <= cur_blank ? 7'h7f : glyph(cur_nib);
                dp  <= ~cur_dp;
            end else begin
                an  <= '1;
                seg <= 7'h7f;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sv_seg_scanner.sv
module tb_sv_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    sv_seg_scanner #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Hand-written copy of the glyph table.
    function automatic logic [6:0] exp_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: exp_glyph = 7'b1000000;
            4'h1: exp_glyph = 7'b1111001;
            4'h2: exp_glyph = 7'b0100100;
            4'h3: exp_glyph = 7'b0110000;
            4'h4: exp_glyph = 7'b0011001;
            4'h5: exp_glyph = 7'b0010010;
            4'h6: exp_glyph = 7'b0000010;
            4'h7: exp_glyph = 7'b1111000;
            4'h8: exp_glyph = 7'b0000000;
            4'h9: exp_glyph = 7'b0010000;
            4'hA: exp_glyph = 7'b0001000;
            4'hB: exp_glyph = 7'b0000011;
            4'hC: exp_glyph = 7'b1000110;
            4'hD: exp_glyph = 7'b0100001;
            4'hE: exp_glyph = 7'b0000110;
            default: exp_glyph = 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    // One edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Load strobe is sampled at edge cyc+1.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        value = v;
        dp_in = d;
        tick();
        load  = 1'b0;
    endtask

    // Check anode of digit d and segment pattern at output cycle n.
    task automatic chk_at(input string tag, input int n, input int d, input logic [6:0] s);
        logic [3:0] an_exp;
        run_to(n);
        an_exp = ~(4'b0001 << d);
        check({tag, "_an"}, 32'(an), 32'(an_exp));
        check({tag, "_seg"}, 32'(seg), 32'(s));
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_lz = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'b1111);
        check("rst_seg", 32'(seg), 32'b1111111);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_fd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Reset scan: each digit held 4 cycles, all showing 0.
        for (int n = 1; n <= 16; n++) begin
            chk_at("scan", n, (n - 1) / 4, 7'b1000000);
            check("scan_fd", 32'(frame_done), 32'd0);
        end
        run_to(17);
        check("scan_fd_wrap", 32'(frame_done), 32'd1);
        check("scan_an_wrap", 32'(an), 32'b1110);
        run_to(18);
        check("scan_fd_low", 32'(frame_done), 32'd0);

        // Glyph sweep: one load per two frames; nibble d of load i is 4i+d.
        for (int i = 0; i < 4; i++) begin
            logic [15:0] v;
            v = {4'(4 * i + 3), 4'(4 * i + 2), 4'(4 * i + 1), 4'(4 * i)};
            run_to(19 + 32 * i);
            do_load(v, 4'b0000);
            run_to(33 + 32 * i);
            check("sweep_fd", 32'(frame_done), 32'd1);
            for (int d = 0; d < 4; d++) begin
                chk_at("sweep", 34 + 32 * i + 4 * d, d, exp_glyph(4'(4 * i + d)));
                check("sweep_dp", 32'(dp), 32'd1);
            end
        end
        // Digit 3 of 0xFEDC is F.
        check("sweep_f", 32'(seg), 32'b0001110);

        // Mid-frame load: rest of frame keeps 0xFEDC.
        run_to(149);
        do_load(16'h1234, 4'b0000);
        chk_at("tear_old2", 154, 2, 7'b0000110);
        chk_at("tear_old3", 158, 3, 7'b0001110);
        run_to(161);
        check("tear_fd", 32'(frame_done), 32'd1);
        chk_at("tear_new0", 162, 0, 7'b0011001);
        chk_at("tear_new1", 166, 1, 7'b0110000);

        // Two loads in one frame: last wins, none shows early.
        run_to(179);
        do_load(16'h1111, 4'b0000);
        chk_at("last_hold", 182, 1, 7'b0110000);
        run_to(184);
        do_load(16'h2222, 4'b0000);
        chk_at("last_d0", 194, 0, 7'b0100100);
        chk_at("last_d3", 206, 3, 7'b0100100);

        // Load on the wrap edge (edge 224) commits immediately.
        run_to(223);
        do_load(16'h5678, 4'b0000);
        chk_at("wrapld_d0", 225, 0, 7'b0000000);
        check("wrapld_fd", 32'(frame_done), 32'd1);
        chk_at("wrapld_d3", 237, 3, 7'b0010010);
        chk_at("wrapld_keep", 242, 0, 7'b0000000);

        // Leading-zero blanking of 0x0040.
        run_to(243);
        blank_lz = 1'b1;
        do_load(16'h0040, 4'b0000);
        chk_at("lz_d0", 258, 0, 7'b1000000);
        chk_at("lz_d1", 262, 1, 7'b0011001);
        chk_at("lz_d2", 266, 2, 7'b1111111);
        chk_at("lz_d3", 270, 3, 7'b1111111);
        run_to(272);
        blank_lz = 1'b0;
        chk_at("nolz_d0", 274, 0, 7'b1000000);
        chk_at("nolz_d2", 282, 2, 7'b1000000);
        chk_at("nolz_d3", 286, 3, 7'b1000000);
        run_to(289);
        blank_lz = 1'b1;
        do_load(16'h0000, 4'b0000);
        chk_at("zero_d0", 306, 0, 7'b1000000);
        chk_at("zero_d1", 310, 1, 7'b1111111);
        chk_at("zero_d2", 314, 2, 7'b1111111);
        chk_at("zero_d3", 318, 3, 7'b1111111);

        // Decimal point on digit 2 only.
        run_to(323);
        blank_lz = 1'b0;
        do_load(16'h0000, 4'b0100);
        chk_at("dp_d0", 338, 0, 7'b1000000);
        check("dp_d0_dp", 32'(dp), 32'd1);
        chk_at("dp_d1", 342, 1, 7'b1000000);
        check("dp_d1_dp", 32'(dp), 32'd1);
        chk_at("dp_d2", 346, 2, 7'b1000000);
        check("dp_d2_dp", 32'(dp), 32'd0);
        chk_at("dp_d3", 350, 3, 7'b1000000);
        check("dp_d3_dp", 32'(dp), 32'd1);

        // Enable low blanks pins; phase continues underneath.
        run_to(354);
        enable = 1'b0;
        run_to(355);
        check("en_off_an", 32'(an), 32'b1111);
        check("en_off_seg", 32'(seg), 32'b1111111);
        check("en_off_dp", 32'(dp), 32'd1);
        run_to(360);
        check("en_off_an2", 32'(an), 32'b1111);
        run_to(361);
        enable = 1'b1;
        run_to(362);
        check("en_on_an", 32'(an), 32'b1011);
        check("en_on_dp", 32'(dp), 32'd0);
        run_to(366);
        check("en_on_an3", 32'(an), 32'b0111);

        // Async reset between edges with a pending load.
        run_to(369);
        do_load(16'h9999, 4'b1111);
        #3;
        rst = 1'b1;
        #1;
        check("arst_an", 32'(an), 32'b1111);
        check("arst_seg", 32'(seg), 32'b1111111);
        check("arst_dp", 32'(dp), 32'd1);
        check("arst_fd", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        chk_at("arst_first", 1, 0, 7'b1000000);
        check("arst_first_dp", 32'(dp), 32'd1);
        chk_at("arst_wrap_d0", 17, 0, 7'b1000000);
        check("arst_wrap_fd", 32'(frame_done), 32'd1);
        chk_at("arst_wrap_d3", 29, 3, 7'b1000000);
        check("arst_wrap_dp", 32'(dp), 32'd1);
        chk_at("arst_f2_d0", 33, 0, 7'b1000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sv_seg_scanner.md
# sv_seg_scanner

Parametrised, time-multiplexed seven-segment display driver. It accepts an NUM_DIGITS-wide packed hex word, double-buffers it, and scans one digit at a time onto a shared segment bus with per-digit anode select. It adds decimal points, leading-zero blanking and tear-free frame-synchronous updates. It sits between the calculator datapath (result/operand registers) and the board display pins.

## Interface
- NUM_DIGITS, default 4: digits scanned. Legal range 1..8.
- REFRESH_DIV, default 100000: clk cycles each digit is held. Must be >= 1.
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: reset; asynchronous and active-high.
- enable, input, 1: 0 forces all anodes and segments off; the scan keeps running.
- load, input, 1: single-cycle strobe that captures value and dp_in.
- value, input, 4*NUM_DIGITS: nibble k (bits 4k+3:4k) is digit k; digit 0 is the rightmost.
- dp_in, input, NUM_DIGITS: bit k lights the decimal point of digit k.
- blank_lz, input, 1: 1 enables leading-zero suppression (live, not latched).
- seg, output, 7: active-low segments {g,f,e,d,c,b,a}, a = bit 0.
- dp, output, 1: active-low decimal point.
- an, output, NUM_DIGITS: active-low one-hot anode select.
- frame_done, output, 1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- Glyph table, hex to seg: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank = 1111111.
- Prescaler counts 0..REFRESH_DIV-1. Its terminal count is a tick.
- Digit index advances on each tick. It wraps from NUM_DIGITS-1 to 0, which is the wrap event.
- Staging register: load=1 captures value/dp_in and sets pending. A later load before commit overwrites staging, so the last one wins.
- Display register: commits on the wrap event only.
  - If pending=1, it takes the staging contents and clears pending.
  - If load=1 on the same edge as the wrap, the incoming value/dp_in commit directly and pending is left 0.
  - Without a commit, the displayed value never changes mid-frame.
- Leading-zero rule, when blank_lz=1: digit k is blanked (seg=1111111) if its nibble and every nibble above it are 0. Digit 0 is never blanked. dp follows dp_in, so a blanked digit may still show its point.
- Output selection:
  - enable=0: an all 1s, seg=1111111, dp=1.
  - otherwise: an has a 0 only at the current index, seg is the glyph or blank, dp = ~dp bit.

## Timing
- Reset values:
  - prescaler=0, index=0, staging=0, display=0, pending=0.
  - an = all 1s, seg=1111111, dp=1, frame_done=0.
- seg, dp, an and frame_done are registered: one-cycle latency from index/display state to pins.
- First edge after rst deasserts with enable=1: an = ...1110 (digit 0), seg = glyph 0.
- Each digit stays on an for exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- REFRESH_DIV=1: the index advances every cycle.
- NUM_DIGITS=1: every tick is a wrap.
- frame_done is high during the first output cycle of digit 0, i.e. the same cycle the newly committed value first appears on seg.
- Load-to-display latency is at most one frame plus one cycle. Exact latency = cycles to the next wrap edge + 1.
- Changes to enable and blank_lz take effect on the next output cycle. They never disturb the scan phase.
- rst asserted mid-frame: all state and outputs return to reset values immediately. The pending load is discarded.

## Test plan
- Reset/scan, NUM_DIGITS=4, REFRESH_DIV=4: release rst, then observe 16 cycles.
  - an sequence: 1110 x4, 1101 x4, 1011 x4, 0111 x4.
  - seg = 1000000 throughout.
  - frame_done pulses every 16 cycles.
- Glyph sweep: load 0x3210, then 0x7654, 0xBA98, 0xFEDC, one per frame. Each digit shows the table code, e.g. digit 3 of 0xFEDC gives 0001110.
- Tear-free commit:
  - Load 0x1234 mid-frame; the remaining digits still show the old value until the wrap.
  - Load 0x1111 then 0x2222 in the same frame; only 2222 appears.
  - Load on the wrap edge commits that frame.
- Leading-zero blanking: value 0x0040, blank_lz=1.
  - Digits 3 and 2 show 1111111, digit 1 shows 0011001, digit 0 shows 1000000.
  - value 0x0000 shows a lone 0 on digit 0.
  - blank_lz=0 shows 0040.
- Decimal point and enable:
  - dp_in=0100 gives dp=0 only while an=1011.
  - enable=0 gives an=1111, seg=1111111; the scan phase is unchanged on re-enable.
- Async reset mid-frame with pending=1: assert rst between clk edges.
  - Outputs go to reset values before the next edge.
  - After release, 0 is displayed and the pending value never appears.
